div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//  - Raises the EX stall request consumed by the pipeline stall controller.
//  - Holds PC/IF/ID/EX via that controller until the quotient/remainder pair is ready for HI/LO writeback.
//  - One quotient bit per cycle. Can be aborted by a pipeline flush.
// PARAMETERS
//  WIDTH   32  operand width; result bus is 2*WIDTH ({remainder, quotient})
//  CNT_W   6   iteration counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-low reset (rst==0 resets on the clk edge)
//  start_i      in   1        EX holds a DIV/DIVU; held high by EX until ready_o
//  signed_i     in   1        1=DIV (two's complement), 0=DIVU; sampled with start in IDLE
//  dividend_i   in   WIDTH    rs operand; sampled in IDLE on accept
//  divisor_i    in   WIDTH    rt operand; sampled in IDLE on accept
//  annul_i      in   1        flush: abandon current division
//  busy_o       out  1        state != IDLE
//  ready_o      out  1        one-cycle pulse: result_o valid for the current op
//  result_o     out  2*WIDTH  {remainder(HI), quotient(LO)}; held until next accept
//  stallreq_o   out  1        start_i & ~ready_o & ~annul_i (comb.); drives stallreq_for_ex
// BEHAVIOUR
//  Reset (rst==0): state=IDLE, cnt=0, busy_o=0, ready_o=0, result_o=0, internal regs=0.
//  States: IDLE, ZERO, BUSY, DONE (2-bit encoding).
//  IDLE
//   - start_i & ~annul_i & divisor==0  -> ZERO
//   - start_i & ~annul_i & divisor!=0  -> BUSY
//   - On accept: latch |dividend|, |divisor| (abs only when signed_i), neg_q = sign(a)^sign(b), neg_r = sign(a); cnt=0.
//  BUSY, one step per cycle
//   - Shift {rem,quo} left 1; trial = rem - divisor.
//   - If trial does not borrow: rem=trial, quo[0]=1.
//   - cnt++; on cnt==WIDTH-1 -> DONE.
//  ZERO: -> DONE. Result quotient = all ones, remainder = raw dividend (no trap).
//  DONE
//   - ready_o=1. result_o = {neg_r ? -rem : rem, neg_q ? -quo : quo}; result_o registered.
//   - -> IDLE unconditionally.
//   - start_i seen in the following IDLE cycle is a NEW division: EX must have advanced.
//  Latency, start accepted at cycle 0:
//   - ready_o at cycle WIDTH+1 (33 for WIDTH=32).
//   - Divide-by-zero: ready_o at cycle 2.
//  annul_i
//   - Any state -> IDLE next edge. ready_o forced 0 in that cycle; result_o unchanged.
//   - Has priority over start_i.
//  Overflow: signed 0x8000_0000 / -1 -> quotient 0x8000_0000, remainder 0 (natural wrap, no flag).
//  Unsigned magnitudes: all internal arithmetic is WIDTH+1 bits to capture the borrow; no sign extension in BUSY.
//  stallreq_o
//   - Low in the DONE cycle, so the controller releases EX exactly when ready_o is high.
//   - Low when start_i==0.
//  Inputs other than start_i/annul_i are ignored outside IDLE.
// STRUCTURE
//  - lib/defines.vh gains:
//    - DivFree/DivByZero/DivOn/DivEnd state codes
//    - `DivResultBus (=64)
//    - `DivCntBus
//  - No sub-module; the negate/abs helper is a local function.
//  - Single always block for state/cnt/datapath plus a comb. stallreq_o assign.
//  - The EX wrapper ORs stallreq_o into stallreq_for_ex.
// TESTING
//  1. DIVU 100/7: ready_o at cycle 33, result_o={32'd2,32'd14}; stallreq_o high cycles 0..32, low at 33.
//  2. DIV -7/2 -> quo 0xFFFF_FFFD, rem 0xFFFF_FFFF. DIV 7/-2 -> quo 0xFFFF_FFFD, rem 1.
//  3. DIV 0x8000_0000/0xFFFF_FFFF -> quo 0x8000_0000, rem 0. DIVU same operands -> quo 0, rem 0x8000_0000.
//  4. DIVU 5/0: ready_o at cycle 2, result_o={32'd5,32'hFFFF_FFFF}.
//  5. annul_i at cycle 10 of BUSY -> IDLE next edge; no ready_o; result_o keeps the prior value; a new start completes correctly.
//  6. rst=0 at cycle 15 of BUSY -> all outputs 0 next edge; back-to-back start after DONE yields two correct results.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and sizes for the iterative divider used by the EX stage.
package div_iter_pkg;

  // Divider control states, 2-bit encoded.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_RESULT_W = 2 * DIV_WIDTH;
  localparam int DIV_CNT_W    = 6;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU; produces one quotient bit per
// cycle, holds the pipeline through stallreq_o and can be cancelled by a flush.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               stallreq_o
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Conditional two's-complement negation, also used to take magnitudes.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  // One restoring step: the extra top bit of the trial subtraction is the borrow.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  assign busy_o = (state != DIV_FREE);

  // Stall EX while a division is pending; release in the cycle the result appears.
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  // Control state, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else if (annul_i) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            rem     <= '0;
            quo     <= neg_if(signed_i & dividend_i[WIDTH-1], dividend_i);
            divisor <= neg_if(signed_i & divisor_i[WIDTH-1], divisor_i);
            neg_q   <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r   <= signed_i & dividend_i[WIDTH-1];
            cnt     <= '0;
            state   <= (divisor_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          result_o <= {neg_if(neg_r, quo), {WIDTH{1'b1}}};
          ready_o  <= 1'b1;
          state    <= DIV_END;
        end
        DIV_ON: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result_o <= {neg_if(neg_r, rem_next), neg_if(neg_q, quo_next)};
            ready_o  <= 1'b1;
            state    <= DIV_END;
          end
        end
        DIV_END: begin
          ready_o <= 1'b0;
          state   <= DIV_FREE;
        end
        default: begin
          ready_o <= 1'b0;
          state   <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: the driver queues expected results and
// their due cycle, a monitor checks them whenever ready_o is seen.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
  logic        stallreq_o;

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .stallreq_o (stallreq_o)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor pops the scoreboard on each result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready got result 0x%0h expected no pulse", result_o);
      end else begin
        e = sb.pop_front();
        checkOutput(e.name, result_o, e.res);
        checkOutput({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Starts one division, checks stallreq each cycle, returns in the ready cycle with start_i still high.
  task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp_res, input int lat);
    int  n;
    bit  got;
    exp_t e;
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    e.res  = exp_res;
    e.due  = cyc + lat;
    e.name = name;
    sb.push_back(e);
    #1;
    n   = 0;
    got = 0;
    while (!got && n < 60) begin
      if (ready_o) begin
        got = 1;
      end else begin
        checkOutput({name, "_stall_high"}, 64'(stallreq_o), 64'd1);
        @(negedge clk);
        n++;
      end
    end
    if (got) begin
      checkOutput({name, "_stall_low"}, 64'(stallreq_o), 64'd0);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout got no ready_o expected one within 60 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic endOp();
    start_i = 1'b0;
    @(negedge clk);
  endtask

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    annul_i    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;

    applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    endOp();
    checkOutput("idle_stall_low", 64'(stallreq_o), 64'd0);
    checkOutput("idle_busy_low", 64'(busy_o), 64'd0);
    checkOutput("result_held", result_o, {32'd2, 32'd14});

    applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    endOp();
    applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    endOp();
    applyStimulus("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    endOp();
    applyStimulus("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);
    endOp();
    applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    endOp();
    applyStimulus("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
    endOp();
    applyStimulus("div_0_5", 1'b1, 32'd0, 32'd5, {32'd0, 32'd0}, 33);
    endOp();
    applyStimulus("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2);
    endOp();
    applyStimulus("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2);
    endOp();

    // Flush in the middle of a division.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    checkOutput("annul_stall_low", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    checkOutput("annul_busy_low", 64'(busy_o), 64'd0);
    checkOutput("annul_ready_low", 64'(ready_o), 64'd0);
    checkOutput("annul_result_kept", result_o, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    repeat (40) @(negedge clk);
    applyStimulus("divu_after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
    endOp();

    // Reset in the middle of a division.
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd77;
    divisor_i  = 32'd5;
    repeat (15) @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy_o), 64'd0);
    checkOutput("midrst_ready", 64'(ready_o), 64'd0);
    checkOutput("midrst_result", result_o, 64'd0);
    checkOutput("midrst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back: start stays high straight into the next operation.
    applyStimulus("b2b_first", 1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 33);
    applyStimulus("b2b_second", 1'b1, 32'hFFFF_CFC7, 32'd100, {32'hFFFF_FFD3, 32'hFFFF_FF85}, 33);
    endOp();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
